// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 key decoding path: prefix byte values,
//   the set of receiver status bytes that never form part of a key
//   sequence, and the prefix-tracking FSM state type.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;  // extended-key prefix
  localparam logic [7:0] PS2_BRK = 8'hF0;  // break (release) prefix

  // Status/error bytes a keyboard may send. They are never key codes and
  // abort any prefix sequence in progress.
  localparam int unsigned PS2_N_IGNORED = 5;
  localparam logic [7:0] PS2_IGNORED [PS2_N_IGNORED] =
    '{8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  function automatic logic ps2_is_ignored(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_N_IGNORED; i++) begin
      if (code == PS2_IGNORED[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// ps2_ascii_lut
//   Combinational translation of a PS/2 set-2 base scancode to ASCII.
//   Covers lowercase letters, digits, space and enter; every other code
//   maps to 8'h00. The extended-key qualification is applied by the caller.
// Ports
//   code   in  8  base scancode (prefixes already removed)
//   ascii  out 8  ASCII character, or 8'h00 when unmapped
module ps2_ascii_lut
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  always_comb begin
    // NOTE: default assigned before the case so unmapped codes cannot infer a latch.
    ascii = 8'h00;
    unique case (code)
      8'h1C: ascii = 8'h61;  // a
      8'h32: ascii = 8'h62;  // b
      8'h21: ascii = 8'h63;  // c
      8'h23: ascii = 8'h64;  // d
      8'h24: ascii = 8'h65;  // e
      8'h2B: ascii = 8'h66;  // f
      8'h34: ascii = 8'h67;  // g
      8'h33: ascii = 8'h68;  // h
      8'h43: ascii = 8'h69;  // i
      8'h3B: ascii = 8'h6A;  // j
      8'h42: ascii = 8'h6B;  // k
      8'h4B: ascii = 8'h6C;  // l
      8'h3A: ascii = 8'h6D;  // m
      8'h31: ascii = 8'h6E;  // n
      8'h44: ascii = 8'h6F;  // o
      8'h4D: ascii = 8'h70;  // p
      8'h15: ascii = 8'h71;  // q
      8'h2D: ascii = 8'h72;  // r
      8'h1B: ascii = 8'h73;  // s
      8'h2C: ascii = 8'h74;  // t
      8'h3C: ascii = 8'h75;  // u
      8'h2A: ascii = 8'h76;  // v
      8'h1D: ascii = 8'h77;  // w
      8'h22: ascii = 8'h78;  // x
      8'h35: ascii = 8'h79;  // y
      8'h1A: ascii = 8'h7A;  // z
      8'h45: ascii = 8'h30;  // 0
      8'h16: ascii = 8'h31;  // 1
      8'h1E: ascii = 8'h32;  // 2
      8'h26: ascii = 8'h33;  // 3
      8'h25: ascii = 8'h34;  // 4
      8'h2E: ascii = 8'h35;  // 5
      8'h36: ascii = 8'h36;  // 6
      8'h3D: ascii = 8'h37;  // 7
      8'h3E: ascii = 8'h38;  // 8
      8'h46: ascii = 8'h39;  // 9
      8'h29: ascii = 8'h20;  // space
      8'h5A: ascii = 8'h0D;  // enter
      default: ascii = 8'h00;
    endcase
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns the raw byte stream from the PS/2 receiver into key events.
//   E0/F0 prefixes are folded into ext/release flags, typematic repeats of
//   the currently held key are suppressed, and each remaining make/break is
//   offered through a one-entry valid/ready slot. A held-key register and a
//   wrapping press counter are maintained for display logic.
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   in_valid      one-cycle pulse, in_code carries a received byte
//   in_code [8]   received byte
//   out_valid     event slot occupied
//   out_ready     consumer accepts the event when out_valid && out_ready
//   out_code [8]  base scancode of the event
//   out_ext       event was E0-prefixed
//   out_release   1 = break, 0 = make
//   out_ascii [8] ASCII of a non-extended code, else 0
//   held          a key is currently held
//   held_code [8] base code of the held key
//   press_count   counted make events, wraps modulo 2**CNT_W
//   overflow      sticky: an event was dropped because the slot was full
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_code,
  output logic             out_ext,
  output logic             out_release,
  output logic [7:0]       out_ascii,
  output logic             held,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] press_count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ps2_state_t state_q, state_d;

  logic       cand;       // a key code completed a sequence this cycle
  logic       cand_ext;
  logic       cand_rel;
  logic       held_ext;   // extension bit of the held key ID
  logic       key_match;
  logic       is_repeat;
  logic       emit;
  logic       slot_free;
  logic [7:0] lut_ascii;

  // ---------------- prefix FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cand     = 1'b0;
    cand_ext = 1'b0;
    cand_rel = 1'b0;
    if (in_valid) begin
      if (ps2_is_ignored(in_code)) begin
        state_d = ST_IDLE;
      end else if (in_code == PS2_EXT) begin
        // A second E0, or E0 after a break prefix, leaves the state alone.
        if (state_q == ST_IDLE) state_d = ST_EXT;
      end else if (in_code == PS2_BRK) begin
        unique case (state_q)
          ST_IDLE: state_d = ST_BRK;
          ST_EXT:  state_d = ST_EXT_BRK;
          default: state_d = state_q;
        endcase
      end else begin
        cand     = 1'b1;
        cand_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
        cand_rel = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        state_d  = ST_IDLE;
      end
    end
  end

  // ---------------- event qualification ----------------
  assign key_match = held && (held_ext == cand_ext) && (held_code == in_code);
  assign is_repeat = cand && !cand_rel && key_match;
  assign emit      = cand && !is_repeat;
  assign slot_free = !out_valid || out_ready;

  ps2_ascii_lut u_ascii_lut (
    .code  (in_code),
    .ascii (lut_ascii)
  );

  // ---------------- held key and press counter ----------------
  // These track the keyboard even when the slot drops the event, so the
  // display never drifts from the physical key state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held        <= 1'b0;
      held_ext    <= 1'b0;
      held_code   <= 8'h00;
      press_count <= '0;
    end else if (emit) begin
      if (!cand_rel) begin
        held        <= 1'b1;
        held_ext    <= cand_ext;
        held_code   <= in_code;
        press_count <= press_count + CNT_ONE;
      end else if (key_match) begin
        held <= 1'b0;
      end
    end
  end

  // ---------------- output slot ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_code    <= 8'h00;
      out_ext     <= 1'b0;
      out_release <= 1'b0;
      out_ascii   <= 8'h00;
      overflow    <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (emit) begin
        if (slot_free) begin
          // Loading in the same cycle as a pop keeps the slot occupied.
          out_valid   <= 1'b1;
          out_code    <= in_code;
          out_ext     <= cand_ext;
          out_release <= cand_rel;
          out_ascii   <= cand_ext ? 8'h00 : lut_ascii;
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
